csoc_emu: RTL and testbench

- Synthesizable responder model of the CSoC test interface, the device-side end of the tester's csoc_* pins.
- Lets the tester be brought up in loopback on a second board, or in the same FPGA, before real silicon is available.
- Implements 8 parallel scan chains (test mode) and a byte echo path with a 4-entry FIFO (functional mode).
- All CSoC-side state advances only on synchronized rising edges of csoc_clk_i, sampled in the clk domain.

---
 rtl/csoc_emu.sv | 127 ++++++++++++
 tb/tb_csoc_emu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csoc_emu.sv
// Device-side responder for the CSoC test pins: 8 parallel scan chains in
// test mode and a byte echo through a 4-entry FIFO in functional mode.
module csoc_emu #(
  parameter int CHAIN_LEN = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       csoc_clk_i,
  input  logic       csoc_rstn_i,
  input  logic       csoc_test_se_i,
  input  logic       csoc_test_tm_i,
  input  logic       csoc_uart_read_i,
  input  logic [7:0] csoc_data_i,
  output logic       csoc_uart_write_o,
  output logic [7:0] csoc_data_o,
  output logic       overflow_o,
  output logic [2:0] fifo_count_o
);

  localparam int SYNC_W = 13;
  localparam logic [CHAIN_LEN-1:0] CHAIN_ONE = {{(CHAIN_LEN-1){1'b0}}, 1'b1};

  // All tester inputs share one synchronizer so they stay mutually aligned.
  logic [SYNC_W-1:0] sync_raw, sync_q1, sync_q2;
  logic              clk_prev;

  assign sync_raw = {csoc_clk_i, csoc_rstn_i, csoc_test_se_i, csoc_test_tm_i,
                     csoc_uart_read_i, csoc_data_i};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      clk_prev <= 1'b0;
    end else begin
      sync_q1  <= sync_raw;
      sync_q2  <= sync_q1;
      clk_prev <= sync_q2[12];
    end
  end

  logic       s_clk, s_rstn, s_se, s_tm, s_read;
  logic [7:0] s_data;
  logic       tick;

  assign s_clk  = sync_q2[12];
  assign s_rstn = sync_q2[11];
  assign s_se   = sync_q2[10];
  assign s_tm   = sync_q2[9];
  assign s_read = sync_q2[8];
  assign s_data = sync_q2[7:0];
  assign tick   = s_clk & ~clk_prev;

  logic [CHAIN_LEN-1:0] chain [8];
  logic [7:0]           fifo_mem [4];
  logic [1:0]           rd_ptr, wr_ptr;
  logic [2:0]           count;
  logic [7:0]           data_reg;
  logic                 write_q;
  logic                 overflow_q;

  // Fullness and emptiness are judged on the pre-tick occupancy.
  logic fifo_full, do_pop, do_push;

  assign fifo_full = (count == 3'd4);
  assign do_pop    = ~write_q & (count != 3'd0);
  assign do_push   = s_read & ~fifo_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) chain[i] <= '0;
      for (int j = 0; j < 4; j++) fifo_mem[j] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      data_reg   <= '0;
      write_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (!s_rstn) begin
      for (int i = 0; i < 8; i++) chain[i] <= '0;
      for (int j = 0; j < 4; j++) fifo_mem[j] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      data_reg   <= '0;
      write_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (tick) begin
      if (s_tm) begin
        write_q <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (s_se) chain[i] <= {chain[i][CHAIN_LEN-2:0], s_data[i]};
          else      chain[i] <= chain[i] + CHAIN_ONE;
        end
      end else begin
        write_q <= do_pop;
        if (do_pop) begin
          data_reg <= fifo_mem[rd_ptr];
          rd_ptr   <= rd_ptr + 2'd1;
        end
        if (s_read && fifo_full) overflow_q <= 1'b1;
        if (do_push) begin
          fifo_mem[wr_ptr] <= s_data;
          wr_ptr           <= wr_ptr + 2'd1;
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end
    end
  end

  logic [7:0] scan_out;

  always_comb begin
    scan_out = '0;
    for (int i = 0; i < 8; i++) scan_out[i] = chain[i][CHAIN_LEN-1];
  end

  assign csoc_data_o       = s_tm ? scan_out : data_reg;
  assign csoc_uart_write_o = write_q;
  assign overflow_o        = overflow_q;
  assign fifo_count_o      = count;

endmodule

// File: tb/tb_csoc_emu.sv
// Bench for csoc_emu: tester-side driver, queue-based reference model and a
// per-cycle compare process, plus literal expectations for directed scenarios.
`timescale 1ns/1ps
module tb_csoc_emu;

  localparam int CL = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cclk = 1'b0, crstn = 1'b1, se = 1'b0, tm = 1'b0, rd = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr, ovf;
  logic [7:0] dout;
  logic [2:0] cnt;

  csoc_emu #(.CHAIN_LEN(CL)) dut (
    .clk(clk), .rstn(rstn), .csoc_clk_i(cclk), .csoc_rstn_i(crstn),
    .csoc_test_se_i(se), .csoc_test_tm_i(tm), .csoc_uart_read_i(rd),
    .csoc_data_i(din), .csoc_uart_write_o(wr), .csoc_data_o(dout),
    .overflow_o(ovf), .fifo_count_o(cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Reference model: chains as plain integers, FIFO as a queue.
  logic [CL-1:0] m_chain [8];
  logic [7:0]    m_q [$];
  logic [7:0]    m_data;
  bit            m_wr, m_ovf, m_tm;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_dout();
    logic [7:0] v;
    v = m_data;
    if (m_tm) for (int i = 0; i < 8; i++) v[i] = m_chain[i][CL-1];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_chain[i] = '0;
    m_q.delete();
    m_data = 8'h00;
    m_wr = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_tick(input bit r_n, input bit t, input bit s, input bit rv, input logic [7:0] d);
    bit full, pop;
    m_tm = t;
    if (!r_n) begin
      model_clear();
    end else if (t) begin
      m_wr = 1'b0;
      for (int i = 0; i < 8; i++)
        m_chain[i] = s ? ((m_chain[i] << 1) | CL'(d[i])) : m_chain[i] + 1'b1;
    end else begin
      full = (m_q.size() == 4);
      pop  = !m_wr && (m_q.size() != 0);
      if (pop) m_data = m_q.pop_front();
      m_wr = pop;
      if (rv) begin
        if (full) m_ovf = 1'b1;
        else      m_q.push_back(d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("write", 16'(wr), 16'(m_wr));
      chk("data", 16'(dout), 16'(exp_dout()));
      chk("overflow", 16'(ovf), 16'(m_ovf));
      chk("count", 16'(cnt), 16'(m_q.size()));
    end
  end

  // One tester-side csoc_clk period: setup, rise, high, fall, low.
  task automatic do_tick(input bit r_n, input bit t, input bit s, input bit rv, input logic [7:0] d);
    @(negedge clk);
    check_en = 1'b0;
    crstn = r_n; tm = t; se = s; rd = rv; din = d;
    repeat (4) @(negedge clk);
    cclk = 1'b1;
    model_tick(r_n, t, s, rv, d);
    repeat (5) @(negedge clk);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    cclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_burst(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) do_tick(1, 0, 0, 1, base + 8'(k));
  endtask

  logic [15:0] ser [8];
  logic [7:0]  got [$];
  logic [7:0]  pat;
  logic [6:0]  wr_pat;
  int          peak;

  initial begin
    #10ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    m_tm = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_write", 16'(wr), 16'h0);
    chk("por_data", 16'(dout), 16'h0);
    chk("por_ovf", 16'(ovf), 16'h0);
    chk("por_count", 16'(cnt), 16'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Scan shift: load A5 into every chain position, then shift it out.
    for (int k = 0; k < CL; k++) do_tick(1, 1, 1, 0, 8'hA5);
    chk("shift_a5", 16'(dout), 16'h00A5);
    for (int i = 0; i < 8; i++) ser[i] = '0;
    for (int k = 0; k < CL; k++) begin
      for (int i = 0; i < 8; i++) ser[i] = {ser[i][14:0], dout[i]};
      do_tick(1, 1, 1, 0, 8'h00);
    end
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) chk("shift_serial", ser[i], pat[i] ? 16'hFFFF : 16'h0000);
    chk("shift_drained", 16'(dout), 16'h0000);

    // Capture: chain0 = FFFF wraps to 0, chain1 = 0001 becomes 0002.
    for (int k = 0; k < CL; k++) do_tick(1, 1, 1, 0, {6'b0, (k == CL - 1), 1'b1});
    do_tick(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) ser[i] = '0;
    for (int k = 0; k < CL; k++) begin
      for (int i = 0; i < 8; i++) ser[i] = {ser[i][14:0], dout[i]};
      do_tick(1, 1, 1, 0, 8'h00);
    end
    chk("capture_wrap", ser[0], 16'h0000);
    chk("capture_inc", ser[1], 16'h0002);
    chk("capture_zero_inc", ser[7], 16'h0001);

    // Echo of three bytes.
    do_tick(0, 0, 0, 0, 8'h00);
    got.delete(); wr_pat = '0; peak = 0;
    for (int k = 0; k < 7; k++) begin
      do_tick(1, 0, 0, (k < 3), 8'h41 + 8'(k));
      wr_pat = {wr_pat[5:0], wr};
      if (wr) got.push_back(dout);
      if (int'(cnt) > peak) peak = int'(cnt);
    end
    chk("echo_pulses", 16'(wr_pat), 16'h002A);
    chk("echo_n", 16'(got.size()), 16'd3);
    if (got.size() == 3) begin
      chk("echo_b0", 16'(got[0]), 16'h41);
      chk("echo_b1", 16'(got[1]), 16'h42);
      chk("echo_b2", 16'(got[2]), 16'h43);
    end
    chk("echo_peak", 16'(peak), 16'd2);
    chk("echo_end_count", 16'(cnt), 16'd0);

    // Overflow: eight back-to-back pushes fill the FIFO; the eighth is dropped.
    push_burst(7, 8'h10);
    chk("ovf_not_yet", 16'(ovf), 16'h0);
    do_tick(1, 0, 0, 1, 8'h17);
    chk("ovf_set", 16'(ovf), 16'h1);
    chk("ovf_count", 16'(cnt), 16'd3);
    do_tick(1, 0, 0, 0, 8'h00);
    chk("ovf_sticky", 16'(ovf), 16'h1);
    do_tick(0, 0, 0, 0, 8'h00);
    chk("crst_ovf", 16'(ovf), 16'h0);
    chk("crst_count", 16'(cnt), 16'd0);

    // Mode switch with two bytes pending.
    push_burst(3, 8'h61);
    chk("ms_pending", 16'(cnt), 16'd2);
    for (int k = 0; k < 4; k++) begin
      do_tick(1, 1, k[0], 1, 8'($urandom));
      chk("ms_no_write", 16'(wr), 16'h0);
    end
    chk("ms_fifo_held", 16'(cnt), 16'd2);
    got.delete();
    for (int k = 0; k < 5; k++) begin
      do_tick(1, 0, 0, 0, 8'h00);
      if (wr) got.push_back(dout);
    end
    chk("ms_n", 16'(got.size()), 16'd2);
    if (got.size() == 2) begin
      chk("ms_b0", 16'(got[0]), 16'h62);
      chk("ms_b1", 16'(got[1]), 16'h63);
    end

    // Randomized traffic across both modes.
    for (int k = 0; k < 300; k++)
      do_tick(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0),
              1'($urandom), ($urandom_range(0, 2) != 0), 8'($urandom));

    // Asynchronous reset mid-operation with three bytes queued.
    do_tick(0, 0, 0, 0, 8'h00);
    for (int k = 0; k < CL; k++) do_tick(1, 1, 1, 0, 8'hFF);
    push_burst(5, 8'h30);
    chk("rst_pre_count", 16'(cnt), 16'd3);
    @(negedge clk);
    check_en = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_write", 16'(wr), 16'h0);
    chk("rst_data", 16'(dout), 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    chk("rst_count", 16'(cnt), 16'h0);
    model_clear();
    m_tm = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    do_tick(1, 0, 0, 1, 8'h5A);
    chk("post_rst_count", 16'(cnt), 16'd1);
    chk("post_rst_write", 16'(wr), 16'h0);
    do_tick(1, 0, 0, 0, 8'h00);
    chk("post_rst_echo", 16'(dout), 16'h5A);
    do_tick(1, 1, 0, 0, 8'h00);
    chk("post_rst_chain", 16'(dout), 16'h00);

    @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
